// File: rtl/safety_island_timer_array.sv
// Multi-channel timer: per-channel prescaler, up-counter, compare match and
// overflow detection with level interrupts, behind a single-cycle register port.
module safety_island_timer_array #(
    parameter int unsigned NumTimers  = 1,
    parameter int unsigned CntWidth   = 32,
    parameter int unsigned PrescWidth = 8,
    parameter int unsigned AddrWidth  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_error_o,
    output logic                   reg_ready_o,
    output logic [2*NumTimers-1:0] irq_o
);

    localparam int unsigned ChW = (NumTimers > 1) ? $clog2(NumTimers) : 1;
    localparam logic [AddrWidth:0] WinEnd = (AddrWidth + 1)'(16 * NumTimers);

    logic           addr_bad;
    logic           wr_ok;
    logic           rd_ok;
    logic [ChW-1:0] ch_idx;
    logic [1:0]     reg_sel;
    logic           unused_wdata;

    logic [31:0] rd_ctrl   [NumTimers];
    logic [31:0] rd_count  [NumTimers];
    logic [31:0] rd_cmp    [NumTimers];
    logic [31:0] rd_status [NumTimers];

    assign addr_bad     = ({1'b0, reg_addr_i} >= WinEnd) || (reg_addr_i[1:0] != 2'b00);
    assign wr_ok        = reg_valid_i && reg_write_i && !addr_bad;
    assign rd_ok        = reg_valid_i && !reg_write_i && !addr_bad;
    assign ch_idx       = reg_addr_i[4 +: ChW];
    assign reg_sel      = reg_addr_i[3:2];
    assign reg_error_o  = reg_valid_i && addr_bad;
    assign reg_ready_o  = 1'b1;
    // Only the low bits of the write data land in registers.
    assign unused_wdata = ^reg_wdata_i;

    for (genvar g = 0; g < NumTimers; g++) begin : g_ch
        logic                  en, autoreload, oneshot, cmp_ie, ovf_ie;
        logic                  cmp_pend, ovf_pend;
        logic [PrescWidth-1:0] presc, pc;
        logic [CntWidth-1:0]   count, compare, count_next;
        logic                  sel, wr_ctrl, wr_count, wr_cmp, wr_status;
        logic                  tick, match, all_ones, cmp_set, ovf_set;

        assign sel       = wr_ok && (ch_idx == ChW'(g));
        assign wr_ctrl   = sel && (reg_sel == 2'd0);
        assign wr_count  = sel && (reg_sel == 2'd1);
        assign wr_cmp    = sel && (reg_sel == 2'd2);
        assign wr_status = sel && (reg_sel == 2'd3);

        assign tick     = en && (pc == presc);
        assign match    = (count == compare);
        assign all_ones = &count;

        // Tick-driven counter update and event flags.
        always_comb begin
            count_next = count;
            cmp_set    = 1'b0;
            ovf_set    = 1'b0;
            if (tick) begin
                if (match) begin
                    cmp_set = 1'b1;
                    if (autoreload) begin
                        count_next = '0;
                    end else begin
                        count_next = count + CntWidth'(1);
                        ovf_set    = all_ones;
                    end
                end else begin
                    count_next = count + CntWidth'(1);
                    ovf_set    = all_ones;
                end
            end
        end

        // Channel state; software writes win over the tick except for flag sets.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                en         <= 1'b0;
                autoreload <= 1'b0;
                oneshot    <= 1'b0;
                cmp_ie     <= 1'b0;
                ovf_ie     <= 1'b0;
                presc      <= '0;
                pc         <= '0;
                count      <= '0;
                compare    <= '0;
                cmp_pend   <= 1'b0;
                ovf_pend   <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    en         <= reg_wdata_i[0];
                    autoreload <= reg_wdata_i[1];
                    oneshot    <= reg_wdata_i[2];
                    cmp_ie     <= reg_wdata_i[3];
                    ovf_ie     <= reg_wdata_i[4];
                    presc      <= reg_wdata_i[8 +: PrescWidth];
                end else if (tick && match && oneshot) begin
                    en <= 1'b0;
                end

                if (!en || wr_ctrl || tick) begin
                    pc <= '0;
                end else begin
                    pc <= pc + PrescWidth'(1);
                end

                count <= wr_count ? reg_wdata_i[CntWidth-1:0] : count_next;
                if (wr_cmp) begin
                    compare <= reg_wdata_i[CntWidth-1:0];
                end

                cmp_pend <= (cmp_pend && !(wr_status && reg_wdata_i[0])) || cmp_set;
                ovf_pend <= (ovf_pend && !(wr_status && reg_wdata_i[1])) || ovf_set;
            end
        end

        assign rd_ctrl[g]   = {{(24 - PrescWidth){1'b0}}, presc, 3'b000,
                               ovf_ie, cmp_ie, oneshot, autoreload, en};
        assign rd_count[g]  = 32'(count);
        assign rd_cmp[g]    = 32'(compare);
        assign rd_status[g] = {30'd0, ovf_pend, cmp_pend};

        assign irq_o[2*g]   = cmp_pend && cmp_ie;
        assign irq_o[2*g+1] = ovf_pend && ovf_ie;
    end

    // Combinational read mux; zero unless a valid, in-range read is active.
    always_comb begin
        reg_rdata_o = '0;
        if (rd_ok) begin
            for (int i = 0; i < NumTimers; i++) begin
                if (ch_idx == ChW'(i)) begin
                    case (reg_sel)
                        2'd0:    reg_rdata_o = rd_ctrl[i];
                        2'd1:    reg_rdata_o = rd_count[i];
                        2'd2:    reg_rdata_o = rd_cmp[i];
                        default: reg_rdata_o = rd_status[i];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_safety_island_timer_array.sv
// Bench for safety_island_timer_array: directed scenarios plus random register
// traffic, all checked against a cycle-level behavioural model of each channel.
module tb_safety_island_timer_array;

    localparam int unsigned NT   = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned PW   = 8;
    localparam int unsigned AW   = 16;
    localparam int unsigned CMAX = (1 << CW) - 1;
    localparam logic [31:0] CTRL_MASK = 32'h1F | (((32'd1 << PW) - 1) << 8);

    logic            clk = 1'b0;
    logic            rst;
    logic            valid, write;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata, rdata;
    logic            error, ready;
    logic [2*NT-1:0] irq;

    safety_island_timer_array #(
        .NumTimers (NT),
        .CntWidth  (CW),
        .PrescWidth(PW),
        .AddrWidth (AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .reg_valid_i(valid),
        .reg_write_i(write),
        .reg_addr_i (addr),
        .reg_wdata_i(wdata),
        .reg_rdata_o(rdata),
        .reg_error_o(error),
        .reg_ready_o(ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per channel.
    logic [31:0] m_ctrl [NT];
    int unsigned m_count[NT];
    int unsigned m_cmp  [NT];
    int unsigned m_pc   [NT];
    logic [1:0]  m_pend [NT];

    logic [31:0]     last_rdata;
    logic [2*NT-1:0] last_irq;
    logic            last_error;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) begin
            m_ctrl[i]  = '0;
            m_count[i] = 0;
            m_cmp[i]   = 0;
            m_pc[i]    = 0;
            m_pend[i]  = '0;
        end
    endfunction

    function automatic bit addr_bad(input int unsigned a);
        return (a >= 16 * NT) || ((a % 4) != 0);
    endfunction

    function automatic logic [31:0] model_read(input int unsigned a);
        int unsigned ch = a / 16;
        case ((a % 16) / 4)
            0:       return m_ctrl[ch];
            1:       return m_count[ch];
            2:       return m_cmp[ch];
            default: return {30'd0, m_pend[ch]};
        endcase
    endfunction

    function automatic logic [2*NT-1:0] model_irq();
        logic [2*NT-1:0] r = '0;
        for (int i = 0; i < NT; i++) begin
            r[2*i]   = m_pend[i][0] & m_ctrl[i][3];
            r[2*i+1] = m_pend[i][1] & m_ctrl[i][4];
        end
        return r;
    endfunction

    // Advance every channel by one clock edge with the given bus access.
    function automatic void model_step(input bit v, input bit w, input int unsigned a,
                                       input logic [31:0] d);
        for (int i = 0; i < NT; i++) begin
            bit          en    = m_ctrl[i][0];
            int unsigned presc = (m_ctrl[i] >> 8) & ((1 << PW) - 1);
            bit          tick  = en && (m_pc[i] == presc);
            int unsigned nc    = m_count[i];
            int unsigned npc;
            logic [31:0] nctrl = m_ctrl[i];
            logic [1:0]  set   = 2'b00;
            logic [1:0]  clr   = 2'b00;
            if (tick) begin
                if (m_count[i] == m_cmp[i]) begin
                    set[0] = 1'b1;
                    if (m_ctrl[i][2]) nctrl[0] = 1'b0;
                end
                if (m_count[i] == m_cmp[i] && m_ctrl[i][1]) begin
                    nc = 0;
                end else begin
                    nc = (m_count[i] + 1) % (CMAX + 1);
                    if (m_count[i] == CMAX) set[1] = 1'b1;
                end
            end
            npc = (!en || tick) ? 0 : m_pc[i] + 1;
            if (v && w && !addr_bad(a) && (a / 16) == i) begin
                case ((a % 16) / 4)
                    0: begin nctrl = d & CTRL_MASK; npc = 0; end
                    1: nc = d & CMAX;
                    2: m_cmp[i] = d & CMAX;
                    default: clr = d[1:0];
                endcase
            end
            m_pend[i]  = (m_pend[i] & ~clr) | set;
            m_ctrl[i]  = nctrl;
            m_count[i] = nc;
            m_pc[i]    = npc;
        end
    endfunction

    // One bus cycle: drive at negedge, check combinational outputs, then step the model.
    task automatic access(input bit v, input bit w, input int unsigned a, input logic [31:0] d);
        logic [31:0] er;
        bit          bad;
        @(negedge clk);
        valid = v;
        write = w;
        addr  = AW'(a);
        wdata = d;
        #1;
        bad = addr_bad(a);
        er  = (v && !w && !bad) ? model_read(a) : 32'd0;
        check("rdata", rdata, er);
        check("error", {31'd0, error}, {31'd0, v && bad});
        check("irq", {24'd0, irq}, {24'd0, model_irq()});
        check("ready", {31'd0, ready}, 32'd1);
        last_rdata = rdata;
        last_irq   = irq;
        last_error = error;
        @(posedge clk);
        model_step(v, w, a, d);
    endtask

    task automatic rd(input int unsigned a);
        access(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input int unsigned a, input logic [31:0] d);
        access(1'b1, 1'b1, a, d);
    endtask

    initial begin
        logic [31:0] ovf_seq [7];
        ovf_seq = '{32'hFE, 32'hFE, 32'hFE, 32'hFF, 32'hFF, 32'hFF, 32'h00};

        rst   = 1'b1;
        valid = 1'b0;
        write = 1'b0;
        addr  = '0;
        wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_irq", {24'd0, irq}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b0;

        // All registers read zero after reset.
        for (int a = 0; a < 16 * NT; a += 4) begin
            rd(a);
            check("rst_reg", last_rdata, 32'd0);
        end

        // Channel 0: auto-reload with compare 5 at full speed.
        wr(32'h08, 32'd5);
        wr(32'h00, 32'h0000_000B);
        for (int k = 0; k < 7; k++) begin
            rd(32'h04);
            check("ch0_count", last_rdata, k % 6);
            check("ch0_irq", {31'd0, last_irq[0]}, {31'd0, k == 6});
        end
        wr(32'h0C, 32'd1);
        rd(32'h0C);
        check("ch0_w1c", last_rdata, 32'd0);
        check("ch0_irq_clr", {31'd0, last_irq[0]}, 32'd0);
        wr(32'h00, 32'd0);

        // Channel 1: overflow from 0xFE with prescaler 2.
        wr(32'h14, 32'hFE);
        wr(32'h10, 32'h0000_0211);
        for (int k = 0; k < 7; k++) begin
            rd(32'h14);
            check("ch1_count", last_rdata, ovf_seq[k]);
        end
        rd(32'h1C);
        check("ch1_status", last_rdata, 32'd2);
        check("ch1_irq", {24'd0, last_irq}, 32'h08);
        rd(32'h24);
        check("ch2_untouched", last_rdata, 32'd0);
        wr(32'h10, 32'd0);
        wr(32'h1C, 32'd3);

        // Channel 2: one-shot, compare 3, prescaler 1.
        wr(32'h28, 32'd3);
        wr(32'h20, 32'h0000_010D);
        for (int k = 0; k < 9; k++) begin
            rd(32'h2C);
            check("ch2_pend", last_rdata, (k == 8) ? 32'd1 : 32'd0);
        end
        rd(32'h20);
        check("ch2_ctrl", last_rdata, 32'h10C);
        check("ch2_irq", {31'd0, last_irq[4]}, 32'd1);
        rd(32'h24);
        check("ch2_count", last_rdata, 32'd4);
        repeat (3) access(1'b0, 1'b0, 0, 32'd0);
        rd(32'h24);
        check("ch2_hold", last_rdata, 32'd4);

        // Channel 3: W1C racing a match, then COUNT write racing a tick.
        wr(32'h38, 32'd2);
        wr(32'h30, 32'd3);
        repeat (5) rd(32'h3C);
        wr(32'h3C, 32'd1);
        rd(32'h3C);
        check("ch3_set_wins", last_rdata, 32'd1);
        wr(32'h3C, 32'd1);
        rd(32'h3C);
        check("ch3_w1c", last_rdata, 32'd0);
        wr(32'h34, 32'h10);
        rd(32'h34);
        check("ch3_cnt_wr", last_rdata, 32'h10);
        wr(32'h30, 32'd0);

        // Error accesses.
        rd(32'h40);
        check("err_oor", {31'd0, last_error}, 32'd1);
        check("err_oor_data", last_rdata, 32'd0);
        rd(32'h02);
        check("err_mis", {31'd0, last_error}, 32'd1);
        wr(32'h40, 32'hFFFF_FFFF);
        wr(32'h02, 32'hFFFF_FFFF);
        rd(32'h00);
        check("err_nochg", last_rdata, 32'd0);

        // Random traffic against the model, with an asynchronous reset midway.
        for (int it = 0; it < 800; it++) begin
            int unsigned ch  = $urandom_range(0, NT - 1);
            int unsigned rs  = $urandom_range(0, 3);
            int unsigned a   = ch * 16 + rs * 4;
            int unsigned sel = $urandom_range(0, 9);
            logic [31:0] d;
            if ($urandom_range(0, 19) == 0) a = $urandom_range(0, 16 * NT + 15);
            case (rs)
                0:       d = ($urandom & 32'h0000_031E) | 32'($urandom_range(0, 3) != 0);
                1:       d = ($urandom_range(0, 1) != 0) ? $urandom_range(250, 255) : $urandom;
                2:       d = ($urandom_range(0, 3) == 0) ? 32'hFF : $urandom_range(0, 12);
                default: d = $urandom;
            endcase
            if (it == 400) begin
                @(posedge clk);
                #2;
                valid = 1'b0;
                rst   = 1'b1;
                #1;
                check("arst_irq", {24'd0, irq}, 32'd0);
                check("arst_rdata", rdata, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            if (sel < 3) access(1'b0, 1'b0, 0, 32'd0);
            else if (sel < 6) rd(a);
            else wr(a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
